// File: rtl/opseq_pkg.sv
// Shared types for the operand sequencer:
// FSM state codes, operand registers, debounce default.
package opseq_pkg;

  localparam int DEB_DEFAULT = 16;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_ADD  = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [4:0] res;
  } opregs_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stable-count debouncer
// and rising-edge pulse for one raw button.
module btn_debounce
  import opseq_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          lvl;
  logic [CW-1:0] cnt;

  // rise is registered on the same edge the level flips
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      lvl  <= 1'b0;
      cnt  <= '0;
      rise <= 1'b0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      rise <= 1'b0;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt  <= '0;
        lvl  <= s2;
        rise <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_sequencer.sv
// Operand entry FSM for a 4-bit adder: capture A, B/ci,
// register the sum and show it on the LEDs.
module operand_sequencer
  import opseq_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       ci_sw,
  input  logic       btn0,
  input  logic       btn1,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       ci,
  input  logic [4:0] sum_in,
  output logic [4:0] ld,
  output logic [1:0] st
);

  state_t  state;
  state_t  state_n;
  opregs_t ops;
  opregs_t ops_n;
  logic    enter;
  logic    c1;
  logic    clr;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn0 (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn0),
    .rise (enter)
  );

  // clear is a level, synchronized only
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c1  <= 1'b0;
      clr <= 1'b0;
    end else begin
      c1  <= btn1;
      clr <= c1;
    end
  end

  always_comb begin
    state_n = state;
    ops_n   = ops;
    unique case (state)
      S_A: begin
        if (enter) begin
          ops_n.a = sw;
          state_n = S_B;
        end
      end
      S_B: begin
        if (enter) begin
          ops_n.b  = sw;
          ops_n.ci = ci_sw;
          state_n  = S_ADD;
        end
      end
      S_ADD: begin
        ops_n.res = sum_in;
        state_n   = S_SHOW;
      end
      S_SHOW: begin
        if (enter) state_n = S_A;
      end
      default: state_n = S_A;
    endcase
    if (clr) begin
      state_n = S_A;
      ops_n   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_A;
      ops   <= '0;
    end else begin
      state <= state_n;
      ops   <= ops_n;
    end
  end

  always_comb begin
    ld = ops.res;
    unique case (state)
      S_A, S_B: ld = {1'b0, sw};
      default:  ld = ops.res;
    endcase
  end

  assign a  = ops.a;
  assign b  = ops.b;
  assign ci = ops.ci;
  assign st = state;

endmodule

// File: tb/tb_operand_sequencer.sv
// Randomized scoreboard bench for operand_sequencer
// with an attached 4-bit adder model.
module tb_operand_sequencer;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = '0;
  logic       ci_sw = 1'b0;
  logic       btn0 = 1'b0;
  logic       btn1 = 1'b0;
  logic [3:0] a;
  logic [3:0] b;
  logic       ci;
  logic [4:0] sum_in;
  logic [4:0] ld;
  logic [1:0] st;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [4:0] sum;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  assign sum_in = {1'b0, a} + {1'b0, b} + {4'b0, ci};

  operand_sequencer #(
    .DEB_CYCLES(D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .ci_sw (ci_sw),
    .btn0  (btn0),
    .btn1  (btn1),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .sum_in(sum_in),
    .ld    (ld),
    .st    (st)
  );

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // monitor: every arrival in S_SHOW consumes one expectation
  logic [1:0] pst = 2'd0;
  always @(negedge clk) begin
    if (rst_n && st == 2'd3 && pst != 2'd3) begin
      chk("show_from_add", {30'd0, pst}, 32'd2);
      if (q.size() == 0) begin
        chk("unexpected_show", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("show_a", {28'd0, a}, {28'd0, e.a});
        chk("show_b", {28'd0, b}, {28'd0, e.b});
        chk("show_ci", {31'd0, ci}, {31'd0, e.ci});
        chk("show_ld", {27'd0, ld}, {27'd0, e.sum});
      end
    end
    pst = st;
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    btn0 = 1'b1;
    cyc(D + 8);
    btn0 = 1'b0;
    cyc(D + 8);
  endtask

  task automatic enter_ab(logic [3:0] va, logic [3:0] vb,
                          logic vc);
    exp_t e;
    sw = va;
    press();
    @(negedge clk);
    chk("cap_a_st", {30'd0, st}, 32'd1);
    chk("cap_a", {28'd0, a}, {28'd0, va});
    chk("ld_sw", {27'd0, ld}, {28'd0, va});
    @(posedge clk);
    #1;
    sw    = vb;
    ci_sw = vc;
    e.a   = va;
    e.b   = vb;
    e.ci  = vc;
    e.sum = 5'(va) + 5'(vb) + 5'(vc);
    q.push_back(e);
    press();
    @(negedge clk);
    chk("held_show", {30'd0, st}, 32'd3);
    chk("held_b", {28'd0, b}, {28'd0, vb});
    @(posedge clk);
    #1;
  endtask

  task automatic txn(logic [3:0] va, logic [3:0] vb,
                     logic vc);
    enter_ab(va, vb, vc);
    sw = 4'(va + 4'd1);
    press();
    @(negedge clk);
    chk("back_to_a", {30'd0, st}, 32'd0);
    chk("ld_in_a", {27'd0, ld}, {27'd0, 1'b0, sw});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int chg;
    logic [1:0] last;
    logic [3:0] bv;
    logic seq [0:7];
    rst_n = 1'b0;
    sw    = 4'hC;
    cyc(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_st", {30'd0, st}, 32'd0);
    chk("rst_a", {28'd0, a}, 32'd0);
    chk("rst_b", {28'd0, b}, 32'd0);
    chk("rst_ci", {31'd0, ci}, 32'd0);
    chk("rst_ld", {27'd0, ld}, 32'h0C);
    @(posedge clk);
    #1;

    txn(4'b0011, 4'b0101, 1'b0);
    txn(4'b1111, 4'b0001, 1'b1);
    for (int i = 0; i < 16; i++)
      txn(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)));

    // bounce with 2-cycle glitches, then a solid hold
    sw  = 4'h7;
    seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    chg = 0;
    last = st;
    for (int i = 0; i < 30; i++) begin
      btn0 = (i < 8) ? seq[i] : (i < 18);
      @(negedge clk);
      if (st != last) chg++;
      last = st;
      @(posedge clk);
      #1;
    end
    cyc(D + 4);
    @(negedge clk);
    chk("bounce_adv", chg, 1);
    chk("bounce_st", {30'd0, st}, 32'd1);
    chk("bounce_a", {28'd0, a}, 32'd7);
    @(posedge clk);
    #1;
    btn1 = 1'b1;
    cyc(4);
    btn1 = 1'b0;
    cyc(4);

    // clear coinciding with enter in S_B
    sw = 4'h9;
    press();
    sw    = 4'h6;
    ci_sw = 1'b1;
    btn0  = 1'b1;
    repeat (D) @(posedge clk);
    #1;
    btn1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_clr_st", {30'd0, st}, 32'd1);
    chk("pre_clr_a", {28'd0, a}, 32'd9);
    @(posedge clk);
    @(negedge clk);
    chk("clr_st", {30'd0, st}, 32'd0);
    chk("clr_a", {28'd0, a}, 32'd0);
    chk("clr_b", {28'd0, b}, 32'd0);
    chk("clr_ci", {31'd0, ci}, 32'd0);
    chk("clr_ld", {27'd0, ld}, 32'h06);
    cyc(3);
    btn1 = 1'b0;
    cyc(D + 8);
    @(negedge clk);
    chk("no_queue", {30'd0, st}, 32'd0);
    @(posedge clk);
    #1;
    btn0 = 1'b0;
    cyc(D + 8);

    // reset while showing a result
    enter_ab(4'hA, 4'h4, 1'b1);
    sw    = 4'h5;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_st", {30'd0, st}, 32'd0);
    chk("rst2_a", {28'd0, a}, 32'd0);
    chk("rst2_b", {28'd0, b}, 32'd0);
    chk("rst2_ci", {31'd0, ci}, 32'd0);
    chk("rst2_ld", {27'd0, ld}, 32'h05);
    @(posedge clk);
    #1;

    // button held through reset release
    sw    = 4'hB;
    rst_n = 1'b0;
    btn0  = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    for (int i = 1; i <= D + 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_rst_st", {30'd0, st},
          (i >= D + 3) ? 32'd1 : 32'd0);
    end
    cyc(20);
    @(negedge clk);
    chk("hold_once", {30'd0, st}, 32'd1);
    chk("hold_a", {28'd0, a}, 32'hB);
    @(posedge clk);
    #1;
    btn0 = 1'b0;
    cyc(D + 8);
    bv = 4'($urandom_range(0, 15));
    begin
      exp_t e;
      sw    = bv;
      ci_sw = 1'b0;
      e.a   = 4'hB;
      e.b   = bv;
      e.ci  = 1'b0;
      e.sum = 5'd11 + 5'(bv);
      q.push_back(e);
    end
    press();
    @(negedge clk);
    chk("hold_show", {30'd0, st}, 32'd3);
    @(posedge clk);
    #1;
    press();
    cyc(2);

    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
